ps2_kbd_rx_fifo: RTL and testbench
==================================

PS2_KBD_RX_FIFO -- requirements
Module: ps2_kbd_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 40000000, pixel/system clock frequency in Hz.
REQ-002 SHALL have parameter DEPTH, default 16, scancode FIFO entries (power of two, 2..256).
REQ-003 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples needed to accept a PS/2 line level.
REQ-004 SHALL have parameter TIMEOUT_US, default 2000, maximum gap between falling PS/2 clock edges inside a frame.
REQ-005 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-006 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ps2clk  in  1  raw PS/2 clock line, asynchronous.
REQ-008 SHALL have port ps2data  in  1  raw PS/2 data line, asynchronous.
REQ-009 SHALL have port o_code  out  8  scancode at FIFO head.
REQ-010 SHALL have port o_ext  out  1  head entry was preceded by E0.
REQ-011 SHALL have port o_brk  out  1  head entry was preceded by F0 (key release).
REQ-012 SHALL have port o_valid  out  1  FIFO not empty.
REQ-013 SHALL have port i_ready  in  1  consumer pop request; pop occurs when o_valid and i_ready.
REQ-014 SHALL have port o_level  out  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-015 SHALL have ports o_err_frame, o_err_parity, o_overflow  out  1 each  single-cycle error pulses.

Function
REQ-016 SHALL pass ps2clk/ps2data through 2-FF synchronisers then a FILTER_LEN-sample glitch filter; a falling edge of filtered clock is a bit strobe.
REQ-017 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, one transition per bit strobe; IDLE leaves only on strobe with data=0 (start bit); strobe with data=1 in IDLE ignored.
REQ-018 SHALL shift 8 data bits LSB first in DATA, counting 0..7 with a 3-bit counter.
REQ-019 SHALL, in STOP, accept frame if stop bit=1; else pulse o_err_frame and discard.
REQ-020 SHALL load a timeout counter of TIMEOUT_US*CLK_HZ/1e6 cycles on each strobe outside IDLE; on expiry return to IDLE, discard partial frame, pulse o_err_frame.
REQ-021 SHALL treat accepted byte 0xE0 as prefix: set pending ext flag, no push.
REQ-022 SHALL treat accepted byte 0xF0 as prefix: set pending brk flag, no push.
REQ-023 SHALL push any other accepted byte as {ext,brk,code}, then clear both pending flags in the same cycle.
REQ-024 SHALL make a pushed entry visible on o_valid/o_code one cycle after the stop-bit strobe.
REQ-025 SHALL drop the entry and pulse o_overflow when pushing while full with no simultaneous pop; pending flags still cleared.
REQ-026 SHALL perform both when push and pop coincide, including when full (level unchanged) and when empty is impossible (pop needs o_valid).
REQ-027 SHALL wrap read/write pointers modulo DEPTH; o_level never exceeds DEPTH.
REQ-028 SHALL hold o_code/o_ext/o_brk stable while o_valid=1 and i_ready=0.

Reset
REQ-029 SHALL, on rstn_i low, immediately force: FSM IDLE, FIFO empty, o_valid=0, o_level=0, o_code=0x00, o_ext=0, o_brk=0, all error pulses 0, pending flags 0, filters to level 1.
REQ-030 SHALL discard any frame in progress when reset asserts mid-frame; first frame after release is decoded normally.

Configuration
REQ-031 SHALL, with macro PS2_KBD_PARITY_CHECK_EN defined, check odd parity over data+parity bit; mismatch pulses o_err_parity and discards the byte (pending flags kept).
REQ-032 SHALL, without PS2_KBD_PARITY_CHECK_EN, ignore the parity bit; o_err_parity tied 0.

Structure
REQ-033 SHALL place FSM state enum and prefix constants (8'hE0, 8'hF0) in shared package ps2_pkg.
REQ-034 SHALL implement storage in sub-module ps2_sync_fifo (parametrised width 10, DEPTH).

Verification
REQ-035 SHALL test frame 0x1C, good parity, idle bench -> o_valid=1, o_code=0x1C, o_ext=0, o_brk=0, o_level=1.
REQ-036 SHALL test sequence E0,F0,75 -> single entry code=0x75, ext=1, brk=1; level=1.
REQ-037 SHALL test DEPTH+1 frames with i_ready=0 -> level=DEPTH, one o_overflow pulse, head is first code.
REQ-038 SHALL test clock stall after 4 data bits beyond timeout -> o_err_frame pulse, no push; next 0x29 frame received intact.
REQ-039 SHALL test bad parity on 0x1C with macro defined -> o_err_parity pulse, level 0; undefined -> entry 0x1C pushed.
REQ-040 SHALL test 2-cycle glitch on ps2clk (FILTER_LEN=8) -> no strobe, FSM stays IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Receiver FSM states, scancode prefix bytes and a parity helper.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] c_pfx_ext = 8'hE0;
  localparam logic [7:0] c_pfx_brk = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_fifo
// Purpose  : Single-clock FIFO with occupancy count and overflow pulse.
// Revision : 1.0
// ============================================================================
module ps2_sync_fifo
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = $clog2(DEPTH + 1);
  localparam logic [c_lw-1:0] c_full = c_lw'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_lw-1:0]  level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             full_w, empty_w, pop_w, wr_en_w;

  assign full_w  = (level_q == c_full);
  assign empty_w = (level_q == '0);
  assign pop_w   = !empty_w && i_ready;
  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  assign wr_en_w = i_push && (!full_w || pop_w);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = i_push && full_w && !pop_w;
    if (wr_en_w) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_w)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en_w && !pop_w)      level_d = level_q + 1'b1;
    else if (pop_w && !wr_en_w) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_w) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data     = empty_w ? '0 : mem_q[rd_ptr_q];
  assign o_valid    = !empty_w;
  assign o_level    = level_q;
  assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx_fifo
// Purpose  : PS/2 keyboard receiver with E0/F0 prefix folding into a FIFO.
//            Define PS2_KBD_PARITY_CHECK_EN to reject bytes with bad parity.
// Revision : 1.0
// ============================================================================
module ps2_kbd_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 40000000,
  parameter int DEPTH      = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       ps2clk,
  input  logic                       ps2data,
  output logic [7:0]                 o_code,
  output logic                       o_ext,
  output logic                       o_brk,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_err_frame,
  output logic                       o_err_parity,
  output logic                       o_overflow
);

  localparam int c_fw = $clog2(FILTER_LEN + 1);
  localparam longint unsigned c_to_cycles =
      (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int c_tow = (c_to_cycles < 2) ? 1 : $clog2(c_to_cycles + 1);
  localparam logic [c_tow-1:0] c_to_load = c_tow'(c_to_cycles);

  logic [1:0] line_raw_w, line_filt_w;
  assign line_raw_w = {ps2data, ps2clk};

  // Index 0 is the clock line, index 1 the data line; both idle high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [1:0]      sync_q, sync_d;
    logic [c_fw-1:0] cnt_q, cnt_d;
    logic            lvl_q, lvl_d;

    always_comb begin
      sync_d = {sync_q[0], line_raw_w[gi]};
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      if (sync_q[1] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_fw'(FILTER_LEN - 1)) begin
        lvl_d = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sync_q <= 2'b11;
        cnt_q  <= '0;
        lvl_q  <= 1'b1;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
      end
    end

    assign line_filt_w[gi] = lvl_q;
  end

  logic clk_prev_q, clk_prev_d;
  logic strobe_w, data_w;

  assign clk_prev_d = line_filt_w[0];
  assign strobe_w   = clk_prev_q && !line_filt_w[0];
  assign data_w     = line_filt_w[1];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) clk_prev_q <= 1'b1;
    else         clk_prev_q <= clk_prev_d;
  end

  ps2_state_e       state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [c_tow-1:0] to_cnt_q;
  logic             ext_q, brk_q;
  logic             err_frame_q, err_par_q;
  logic             par_bad_w;

`ifdef PS2_KBD_PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_d = (strobe_w && state_q == ST_PARITY) ? data_w : par_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign par_bad_w = !odd_parity_ok(shift_q, par_q);
`else
  assign par_bad_w = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      err_frame_q <= 1'b0;
      err_par_q   <= 1'b0;
    end else begin
      err_frame_q <= 1'b0;
      err_par_q   <= 1'b0;
      if (strobe_w) begin
        to_cnt_q <= c_to_load;
        case (state_q)
          ST_IDLE: begin
            if (!data_w) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q   <= {data_w, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: state_q <= ST_STOP;
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (!data_w)                    err_frame_q <= 1'b1;
            else if (par_bad_w)             err_par_q   <= 1'b1;
            else if (shift_q == c_pfx_ext)  ext_q       <= 1'b1;
            else if (shift_q == c_pfx_brk)  brk_q       <= 1'b1;
            else begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        // Keyboard stopped clocking mid-frame: abandon it.
        if (to_cnt_q == '0) begin
          state_q     <= ST_IDLE;
          err_frame_q <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q - 1'b1;
        end
      end
    end
  end

  logic       push_w;
  logic [9:0] wr_data_w, rd_data_w;

  assign push_w = strobe_w && (state_q == ST_STOP) && data_w && !par_bad_w &&
                  (shift_q != c_pfx_ext) && (shift_q != c_pfx_brk);
  assign wr_data_w = {ext_q, brk_q, shift_q};

  ps2_sync_fifo #(
    .WIDTH (10),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .i_push     (push_w),
    .i_data     (wr_data_w),
    .i_ready    (i_ready),
    .o_data     (rd_data_w),
    .o_valid    (o_valid),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  assign o_ext        = rd_data_w[9];
  assign o_brk        = rd_data_w[8];
  assign o_code       = rd_data_w[7:0];
  assign o_err_frame  = err_frame_q;
  assign o_err_parity = err_par_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx_fifo
// Purpose  : Scoreboard bench; honours PS2_KBD_PARITY_CHECK_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_ps2_kbd_rx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int HALF  = 20;
`ifdef PS2_KBD_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rstn_i, ps2clk, ps2data, i_ready;
  logic [7:0]    o_code;
  logic          o_ext, o_brk, o_valid;
  logic [LW-1:0] o_level;
  logic          o_err_frame, o_err_parity, o_overflow;

  ps2_kbd_rx_fifo #(
    .CLK_HZ     (1000000),
    .DEPTH      (DEPTH),
    .FILTER_LEN (8),
    .TIMEOUT_US (200)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .o_code       (o_code),
    .o_ext        (o_ext),
    .o_brk        (o_brk),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_level      (o_level),
    .o_err_frame  (o_err_frame),
    .o_err_parity (o_err_parity),
    .o_overflow   (o_overflow)
  );

  always #5 clk_i = ~clk_i;

  int         n_vec = 0, n_fail = 0;
  logic [9:0] exp_q[$];
  bit         m_ext = 0, m_brk = 0, ready_en = 0;
  int         exp_frame = 0, exp_par = 0, exp_ovf = 0;
  int         got_frame = 0, got_par = 0, got_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      i_ready = ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  logic       prev_hold = 1'b0;
  logic [9:0] prev_head = '0;
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      prev_hold = 1'b0;
    end else begin
      if (o_err_frame)  got_frame++;
      if (o_err_parity) got_par++;
      if (o_overflow)   got_ovf++;
      if (prev_hold && o_valid) check("hold_head", 32'({o_ext, o_brk, o_code}), 32'(prev_head));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no entry", {o_ext, o_brk, o_code});
        end else begin
          check("pop_head", 32'({o_ext, o_brk, o_code}), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = o_valid && !i_ready;
      prev_head = {o_ext, o_brk, o_code};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {1'(~bad_stop), 1'((~^b) ^ bad_par), b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2data = bits[i];
      cyc(HALF);
      ps2clk = 1'b0;
      cyc(HALF);
      ps2clk = 1'b1;
    end
    cyc(HALF);
    ps2data = 1'b1;
  endtask

  // Reference: what the keyboard byte stream means to a consumer.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop)                exp_frame++;
    else if (bad_par && PAR_EN)  exp_par++;
    else if (b == 8'hE0)         m_ext = 1'b1;
    else if (b == 8'hF0)         m_brk = 1'b1;
    else begin
      if (!ready_en && exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    model_frame(b, bad_par, bad_stop);
    send_bits(frame_bits(b, bad_par, bad_stop), 11);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    ready_en = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && t < 2000) begin
      cyc(1);
      t++;
    end
    check({tag, "_drain_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    ready_en = 1'b0;
    cyc(3);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_err_frame"}, 32'(got_frame), 32'(exp_frame));
    check({tag, "_err_parity"}, 32'(got_par), 32'(exp_par));
    check({tag, "_overflow"}, 32'(got_ovf), 32'(exp_ovf));
  endtask

  task automatic check_head(input string tag, input logic [7:0] code, input bit ext, input bit brk, input int lvl);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_code"}, 32'(o_code), 32'(code));
    check({tag, "_ext"}, 32'(o_ext), 32'(ext));
    check({tag, "_brk"}, 32'(o_brk), 32'(brk));
    check({tag, "_level"}, 32'(o_level), 32'(lvl));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, first;
    bit         bp, bs;
    int         r;

    rstn_i  = 1'b0;
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    cyc(3);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_code", 32'(o_code), 32'd0);
    check("rst_flags", 32'({o_ext, o_brk, o_err_frame, o_err_parity, o_overflow}), 32'd0);
    rstn_i = 1'b1;
    cyc(30);

    send_frame(8'h1C);
    cyc(2);
    check_head("single", 8'h1C, 1'b0, 1'b0, 1);
    drain("single");

    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    cyc(2);
    check_head("prefix", 8'h75, 1'b1, 1'b1, 1);
    drain("prefix");

    first = 8'h00;
    for (int i = 0; i <= DEPTH; i++) begin
      do b = 8'($urandom_range(1, 255)); while (b == 8'hE0 || b == 8'hF0);
      if (i == 0) first = b;
      send_frame(b);
    end
    cyc(2);
    check("full_level", 32'(o_level), 32'(DEPTH));
    check("full_head", 32'(o_code), 32'(first));
    check("full_ovf_pulses", 32'(got_ovf), 32'd1);
    check_counts("full");
    drain("full");

    // Stall after start bit plus four data bits, well past the timeout.
    send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5);
    exp_frame++;
    cyc(400);
    check("stall_valid", 32'(o_valid), 32'd0);
    check_counts("stall");
    send_frame(8'h29);
    cyc(2);
    check_head("after_stall", 8'h29, 1'b0, 1'b0, 1);
    drain("after_stall");

    send_frame(8'h1C, 1'b1, 1'b0);
    cyc(2);
    check("badpar_level", 32'(o_level), 32'(exp_q.size()));
    check_counts("badpar");
    drain("badpar");

    ps2data = 1'b0;
    cyc(5);
    ps2clk = 1'b0;
    cyc(2);
    ps2clk = 1'b1;
    cyc(20);
    ps2data = 1'b1;
    cyc(10);
    send_frame(8'h1C);
    cyc(2);
    check_head("glitch", 8'h1C, 1'b0, 1'b0, 1);
    check_counts("glitch");
    drain("glitch");

    send_frame(8'h33);
    send_frame(8'hE0);
    send_bits(frame_bits(8'h44, 1'b0, 1'b0), 6);
    check("pre_rst_level", 32'(o_level), 32'd1);
    rstn_i = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_level", 32'(o_level), 32'd0);
    check("midrst_code", 32'({o_ext, o_brk, o_code}), 32'd0);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    cyc(3);
    rstn_i = 1'b1;
    cyc(30);
    send_frame(8'h29);
    cyc(2);
    check_head("post_rst", 8'h29, 1'b0, 1'b0, 1);
    drain("post_rst");

    ready_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      b = 8'hE0;
      else if (r < 32) b = 8'hF0;
      else             b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 99) < 10);
      bs = ($urandom_range(0, 99) < 5);
      send_frame(b, bp, bs);
    end
    drain("random");
    check_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
